// File: rtl/audio_pkg.sv
// Shared audio constants and the DAC serializer state encoding.
// Used by the clock generator and the DAC serializer so both agree on
// word length and FIFO sizing.
package audio_pkg;

    localparam int unsigned AUD_DATA_WIDTH = 16;
    localparam int unsigned AUD_FIFO_DEPTH = 4;
    localparam int unsigned AUD_FIFO_AW    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } dac_state_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous show-ahead FIFO holding stereo pairs.
// Ports:
//   iCLK_18_4, iRST_N  clock and async active-low reset
//   wr_en, din         push request and data (ignored when full)
//   rd_en              pop request (ignored when empty)
//   dout               current head entry (show-ahead)
//   full, empty, level occupancy status
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * AUD_DATA_WIDTH,
    parameter int unsigned DEPTH = AUD_FIFO_DEPTH,
    parameter int unsigned AW    = AUD_FIFO_AW
) (
    input  logic             iCLK_18_4,
    input  logic             iRST_N,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty after wrap-around.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + LW'(1);
            if (do_rd) rd_ptr <= rd_ptr + LW'(1);
        end
    end

    // Storage array, no reset needed: contents are only visible once written.
    always_ff @(posedge iCLK_18_4) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified stereo DAC serializer.
// Buffers {L,R} sample pairs in a small FIFO and shifts them MSB first onto
// oAUD_DACDAT, aligned to the generator's BCK/LRCK (edge-detected, not clocks).
// Ports:
//   iCLK_18_4, iRST_N            codec clock, async active-low reset
//   iAUD_BCK, iAUD_LRCK          bit/frame clock levels (LRCK high = left)
//   iSAMPLE_L/R, iSAMPLE_VALID   pair push, accepted when oSAMPLE_READY
//   oSAMPLE_READY, oFIFO_LEVEL   FIFO not full, pairs stored
//   iCLR_UNDERRUN, oUNDERRUN     sticky "frame started on empty FIFO" flag
//   oAUD_DACDAT                  serial data to the codec
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AUD_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = AUD_FIFO_DEPTH,
    parameter int unsigned FIFO_AW    = AUD_FIFO_AW
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_LRCK,
    input  logic [DATA_WIDTH-1:0] iSAMPLE_L,
    input  logic [DATA_WIDTH-1:0] iSAMPLE_R,
    input  logic                  iSAMPLE_VALID,
    output logic                  oSAMPLE_READY,
    output logic [FIFO_AW:0]      oFIFO_LEVEL,
    input  logic                  iCLR_UNDERRUN,
    output logic                  oUNDERRUN,
    output logic                  oAUD_DACDAT
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic                  bck_q;
    logic                  lrck_q;
    logic                  bck_fall;
    logic                  lr_rise;
    logic                  lr_fall;
    dac_state_e            state;
    logic [PW-1:0]         fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pair_reg;   // R half of the popped pair; L goes straight to shift_reg
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;

    assign bck_fall = bck_q & ~iAUD_BCK;
    assign lr_rise  = ~lrck_q & iAUD_LRCK;
    assign lr_fall  = lrck_q & ~iAUD_LRCK;

    // A same-cycle push into an empty FIFO is not bypassed to the pop.
    assign push          = iSAMPLE_VALID & ~fifo_full;
    assign pop           = lr_rise & ~fifo_empty;
    assign oSAMPLE_READY = ~fifo_full;

    audio_sample_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .wr_en     (push),
        .din       ({iSAMPLE_L, iSAMPLE_R}),
        .rd_en     (pop),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (oFIFO_LEVEL)
    );

    // BCK/LRCK history for edge detection.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            bck_q  <= 1'b0;
            lrck_q <= 1'b0;
        end else begin
            bck_q  <= iAUD_BCK;
            lrck_q <= iAUD_LRCK;
        end
    end

    // Slot FSM and shifter; LR edges win over a coincident BCK fall.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= IDLE;
            pair_reg    <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            oAUD_DACDAT <= 1'b0;
        end else if (lr_rise) begin
            state   <= LEFT;
            bit_cnt <= CW'(1);
            if (fifo_empty) begin
                pair_reg    <= '0;
                shift_reg   <= '0;
                oAUD_DACDAT <= 1'b0;
            end else begin
                pair_reg    <= fifo_dout[DATA_WIDTH-1:0];
                shift_reg   <= fifo_dout[PW-1:DATA_WIDTH];
                oAUD_DACDAT <= fifo_dout[PW-1];
            end
        end else if (lr_fall && state == LEFT) begin
            state       <= RIGHT;
            bit_cnt     <= CW'(1);
            shift_reg   <= pair_reg;
            oAUD_DACDAT <= pair_reg[DATA_WIDTH-1];
        end else if (bck_fall && !lr_fall && state != IDLE) begin
            if (bit_cnt < CW'(DATA_WIDTH)) begin
                shift_reg   <= shift_reg << 1;
                oAUD_DACDAT <= shift_reg[DATA_WIDTH-2];
                bit_cnt     <= bit_cnt + CW'(1);
            end else begin
                oAUD_DACDAT <= 1'b0;
            end
        end
    end

    // Sticky underrun; a new underrun beats a same-cycle clear.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            oUNDERRUN <= 1'b0;
        end else if (lr_rise && fifo_empty) begin
            oUNDERRUN <= 1'b1;
        end else if (iCLR_UNDERRUN) begin
            oUNDERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: a free-running BCK/LRCK generator, a
// frame-level model (pair queue + slot/bit position) checked every cycle,
// and directed scenarios with literal expectations.
module tb_audio_dac_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        clr_underrun = 1'b0;
    logic        ready;
    logic [2:0]  level;
    logic        underrun;
    logic        dacdat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Clock generator stand-in: BCK = 12 clk, LRCK = 384 clk, LRCK edges on BCK falls.
    int unsigned gen_cnt = 200;
    logic        aud_bck;
    logic        aud_lrck;
    always @(posedge clk) gen_cnt <= (gen_cnt == 383) ? 0 : gen_cnt + 1;
    assign aud_bck  = (gen_cnt % 12) >= 6;
    assign aud_lrck = gen_cnt < 192;

    audio_dac_serializer dut (
        .iCLK_18_4     (clk),
        .iRST_N        (rst_n),
        .iAUD_BCK      (aud_bck),
        .iAUD_LRCK     (aud_lrck),
        .iSAMPLE_L     (sample_l),
        .iSAMPLE_R     (sample_r),
        .iSAMPLE_VALID (sample_valid),
        .oSAMPLE_READY (ready),
        .oFIFO_LEVEL   (level),
        .iCLR_UNDERRUN (clr_underrun),
        .oUNDERRUN     (underrun),
        .oAUD_DACDAT   (dacdat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [31:0] mq[$];
    bit          m_under    = 1'b0;
    int          m_slot     = 0;      // 0 none, 1 left, 2 right
    int          m_j        = 0;      // BCK rises seen in current slot
    logic [31:0] m_pair     = '0;
    bit          m_lrck_q   = 1'b0;
    bit          m_bck_prev = 1'b0;
    logic [15:0] cap        = '0;
    logic [15:0] last_l     = '0;
    logic [15:0] last_r     = '0;
    bit          m_rise;
    bit          m_fall;
    int          m_lvl;
    logic [15:0] m_half;
    logic        m_bit;

    // Outputs are checked mid-cycle, then the model steps for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_level", 32'(level), 32'd0);
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_underrun", 32'(underrun), 32'd0);
            chk("rst_dacdat", 32'(dacdat), 32'd0);
            mq.delete();
            m_under  = 1'b0;
            m_slot   = 0;
            m_j      = 0;
            m_pair   = '0;
            m_lrck_q = 1'b0;
        end else begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("ready", 32'(ready), 32'(mq.size() < 4));
            chk("underrun", 32'(underrun), 32'(m_under));
            if (aud_bck && !m_bck_prev) begin
                m_half = (m_slot == 1) ? m_pair[31:16] : m_pair[15:0];
                m_bit  = (m_slot != 0 && m_j < 16) ? m_half[15 - m_j] : 1'b0;
                chk("dacdat", 32'(dacdat), 32'(m_bit));
                if (m_slot != 0 && m_j < 16) begin
                    cap = {cap[14:0], dacdat};
                    if (m_j == 15) begin
                        if (m_slot == 1) last_l = cap;
                        else             last_r = cap;
                    end
                end
                m_j++;
            end
            m_rise = aud_lrck && !m_lrck_q;
            m_fall = !aud_lrck && m_lrck_q;
            m_lvl  = mq.size();
            if (m_rise) begin
                if (m_lvl == 0) begin
                    m_pair  = '0;
                    m_under = 1'b1;
                end else begin
                    m_pair = mq.pop_front();
                end
                m_slot = 1;
                m_j    = 0;
            end else if (m_fall && m_slot == 1) begin
                m_slot = 2;
                m_j    = 0;
            end
            if (clr_underrun && !(m_rise && m_lvl == 0)) m_under = 1'b0;
            if (sample_valid && m_lvl < 4) mq.push_back({sample_l, sample_r});
            m_lrck_q = aud_lrck;
        end
        m_bck_prev = aud_bck;
    end

    // Wait (bounded) for the cycle in which LRCK has just risen; optionally push then.
    task automatic wait_rise(input bit push_at_rise);
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = aud_lrck;
        for (int i = 0; i < 800 && !found; i++) begin
            @(posedge clk); #1;
            if (aud_lrck && !prev) found = 1'b1;
            else prev = aud_lrck;
        end
        chk("lr_rise_seen", 32'(found), 32'd1);
        if (found && push_at_rise) begin
            sample_valid = 1'b1;
            @(posedge clk); #1;
            sample_valid = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] push_l [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    logic [15:0] push_r [5] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE};

    initial begin
        // Reset state
        cycles(3);
        chk("t0_level", 32'(level), 32'd0);
        chk("t0_ready", 32'(ready), 32'd1);
        rst_n = 1'b1;
        cycles(2);

        // Basic frame: A5F0 / 0F0F
        sample_l = 16'hA5F0; sample_r = 16'h0F0F; sample_valid = 1'b1;
        cycles(1);
        sample_valid = 1'b0;
        chk("t1_level", 32'(level), 32'd1);
        wait_rise(1'b0);
        cycles(381);
        chk("t1_left", 32'(last_l), 32'h0000A5F0);
        chk("t1_right", 32'(last_r), 32'h00000F0F);
        chk("t1_underrun", 32'(underrun), 32'd0);

        // Underrun, clear, re-set
        wait_rise(1'b0);
        cycles(2);
        chk("t2_underrun_set", 32'(underrun), 32'd1);
        clr_underrun = 1'b1;
        cycles(1);
        clr_underrun = 1'b0;
        chk("t2_underrun_clr", 32'(underrun), 32'd0);
        wait_rise(1'b0);
        cycles(2);
        chk("t2_underrun_reset", 32'(underrun), 32'd1);
        cycles(198);
        chk("t2_left_zero", 32'(last_l), 32'd0);

        // Overfill: reset in the right slot, push 5 back-to-back
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        for (int k = 0; k < 5; k++) begin
            sample_l = push_l[k]; sample_r = push_r[k]; sample_valid = 1'b1;
            cycles(1);
            if (k == 3) chk("t3_ready_low", 32'(ready), 32'd0);
        end
        sample_valid = 1'b0;
        chk("t3_level_full", 32'(level), 32'd4);
        wait_rise(1'b0);
        chk("t3_level_prepop", 32'(level), 32'd4);
        cycles(1);
        chk("t3_level_pop", 32'(level), 32'd3);
        chk("t3_ready_pop", 32'(ready), 32'd1);
        cycles(380);
        chk("t3_first_left", 32'(last_l), 32'h00001111);
        chk("t3_first_right", 32'(last_r), 32'h0000AAAA);

        // Valid held high with FIFO full for 8 frames
        sample_valid = 1'b1;
        for (int f = 0; f < 8; f++) begin
            sample_l = 16'h3000 + 16'(f);
            sample_r = 16'hC000 + 16'(f);
            wait_rise(1'b0);
        end
        cycles(10);
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_underrun", 32'(underrun), 32'd0);
        sample_valid = 1'b0;

        // Reset mid-left at bit 7
        wait_rise(1'b0);
        cycles(90);
        rst_n = 1'b0;
        #1;
        chk("t5_dacdat", 32'(dacdat), 32'd0);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_underrun", 32'(underrun), 32'd0);
        chk("t5_ready", 32'(ready), 32'd1);
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        clr_underrun = 1'b1;
        cycles(1);
        clr_underrun = 1'b0;

        // Push coincident with lr_rise on an empty FIFO
        sample_l = 16'h8001; sample_r = 16'h7FFE;
        wait_rise(1'b1);
        chk("t6_underrun", 32'(underrun), 32'd1);
        chk("t6_level", 32'(level), 32'd1);
        cycles(380);
        chk("t6_left_zero", 32'(last_l), 32'd0);
        chk("t6_right_zero", 32'(last_r), 32'd0);
        wait_rise(1'b0);
        cycles(381);
        chk("t6_next_left", 32'(last_l), 32'h00008001);
        chk("t6_next_right", 32'(last_r), 32'h00007FFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Downstream consumer of the audio clock generator: takes stereo 16-bit sample pairs from the CPU/MMIO side through a small FIFO and shifts them onto the codec DAC data line in left-justified format, aligned to the generator's BCK/LRCK. It runs entirely in the 18.432 MHz codec clock domain. BCK/LRCK arrive as registered signals from that domain and are edge-detected, not used as clocks.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per channel; must equal the BCK periods per LRCK half-period.
- FIFO_DEPTH, 4, stereo pairs buffered; power of two, ≥2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports. One clock; reset is asynchronous and active-low, named as the codebase does:
- iCLK_18_4  in  1  codec reference clock, 18.432 MHz.
- iRST_N  in  1  asynchronous active-low reset.
- iAUD_BCK  in  1  bit clock from the clock generator.
- iAUD_LRCK  in  1  frame clock; high = left channel, low = right.
- iSAMPLE_L  in  DATA_WIDTH  left sample, two's complement.
- iSAMPLE_R  in  DATA_WIDTH  right sample.
- iSAMPLE_VALID  in  1  push request.
- oSAMPLE_READY  out  1  FIFO not full.
- oFIFO_LEVEL  out  FIFO_AW+1  pairs currently stored.
- iCLR_UNDERRUN  in  1  clears the sticky underrun flag.
- oUNDERRUN  out  1  sticky: a frame started with the FIFO empty.
- oAUD_DACDAT  out  1  serial DAC data, MSB first.

## Operation
- Push: a pair is written when iSAMPLE_VALID && oSAMPLE_READY on a clock edge. The pair is stored as {L,R} (2·DATA_WIDTH bits).
- Edge detect: register iAUD_BCK and iAUD_LRCK once (bck_q, lrck_q).
  - bck_fall = bck_q & ~iAUD_BCK.
  - lr_rise = ~lrck_q & iAUD_LRCK.
  - lr_fall = lrck_q & ~iAUD_LRCK.
- FSM states: IDLE, LEFT, RIGHT.
  - IDLE: the state after reset. DACDAT = 0. On lr_rise, go to LEFT.
  - LEFT, entered on lr_rise:
    - Pop the FIFO head into pair_reg.
    - If the FIFO is empty, load zeros into pair_reg and set oUNDERRUN.
    - Load shift_reg with the L half and output its MSB.
    - bit_cnt = 1.
  - RIGHT, entered on lr_fall from LEFT: load shift_reg with pair_reg R. No FIFO access. Output its MSB. bit_cnt = 1.
  - lr_rise in RIGHT goes to LEFT.
  - Shifting: on bck_fall with no LR edge in the same cycle and bit_cnt < DATA_WIDTH, shift left, output the new MSB, bit_cnt++.
  - Once bit_cnt = DATA_WIDTH, further bck_fall drive DACDAT = 0 until the next LR edge.
  - An LR edge takes priority over bck_fall in the same cycle. In the default configuration they always coincide at slot boundaries.
- Simultaneous push and pop: both take effect, and the level is unchanged.
  - When the FIFO is empty, a same-cycle push is not bypassed. The pop sees empty, which counts as an underrun, and the push is stored.
  - When the FIFO is full, ready is low, so no push happens. The pop frees a slot, and ready goes high the next cycle.
- oUNDERRUN: set has priority over iCLR_UNDERRUN in the same cycle.
- Reset (including mid-frame):
  - FIFO empty, level 0, ready 1.
  - State IDLE, DACDAT 0, oUNDERRUN 0.
  - shift_reg, pair_reg and bit_cnt cleared.
  - bck_q and lrck_q reset to 0.

## Timing
- Default clocks: BCK period is 12 clk and LRCK period is 384 clk (16 BCK per channel). LRCK edges coincide with BCK falling edges.
- DACDAT update latency: 2 clk after the generator register changes (1 input register plus 1 output register). Data is stable ≥3 clk before the next BCK rise. The codec samples on BCK rise.
- Left-justified format: MSB is valid at the first BCK rise after the LRCK edge, and the LSB at the 16th.
- Pop happens in the lr_rise cycle. oFIFO_LEVEL and oSAMPLE_READY reflect it on the following cycle.
- Push to level update: 1 clk. oSAMPLE_READY is registered-equivalent (derived from level).
- Sample throughput is one pair per 384 clk (48 kHz).

## Structure
- Shared package (audio_pkg): AUD_DATA_WIDTH = 16, FIFO depth constant, state encoding (IDLE=2'd0, LEFT=2'd1, RIGHT=2'd2), shared with the clock generator's parameters.
- Sub-module audio_sample_fifo: synchronous FIFO with width 2·DATA_WIDTH and FIFO_DEPTH entries. It provides wr_en, rd_en, dout (show-ahead), full, empty and level, with wrap-around pointers of FIFO_AW+1 bits.
- The top level holds the edge detectors, FSM, shift register and underrun flag.

## Test plan
- The bench instantiates the clock generator driving the DUT. Push L=16'hA5F0, R=16'h0F0F before the first LRCK rise. DACDAT sampled at successive BCK rises must read 1010010111110000 with LRCK high, then 0000111100001111 with LRCK low. oUNDERRUN stays 0.
- Push nothing, then run two frames. DACDAT stays 0 and oUNDERRUN = 1 after the first lr_rise. Assert iCLR_UNDERRUN for 1 clk: it drops, then re-sets at the next frame.
- Push 5 pairs back-to-back before any frame. Ready falls after the 4th, the 5th is not accepted, and level = 4. After one lr_rise, level = 3 and ready = 1 the next cycle. Output order matches push order.
- Hold valid high continuously with the FIFO full. Each frame accepts exactly one pair in the cycle after the pop. Level stays 4 and there is no underrun over 8 frames.
- Deassert iRST_N mid-left-channel, at bit 7. DACDAT, level, oUNDERRUN and ready go to 0/0/0/1 immediately. After release, DACDAT stays 0 until the first lr_rise.
- Push in the same cycle as lr_rise with the FIFO empty. An underrun is flagged, that frame outputs zeros, and the pushed pair plays in the next frame.
